// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - Sequential UART-to-memory loader (LOAD) and memory-to-UART dumper (DUMP).
// Optional running XOR checksum output enabled by defining UART_LOADER_CHECKSUM_EN.
module uart_mem_loader #(
  parameter int WORD_SIZE  = 24,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  startLoad,
  input  logic                  startDump,
  input  logic [ADDR_WIDTH:0]   transLen,
  input  logic                  new_rx_data_indicate,
  input  logic [WORD_SIZE-1:0]  dataToMem,
  input  logic                  txReady,
  input  logic [WORD_SIZE-1:0]  memRdData,
  output logic                  memWrEn,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [WORD_SIZE-1:0]  memWrData,
  output logic                  txStart,
  output logic [WORD_SIZE-1:0]  dataFromMem,
  output logic                  busy,
  output logic                  done
`ifdef UART_LOADER_CHECKSUM_EN
  ,
  output logic [WORD_SIZE-1:0]  checksum
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DUMP_RD,
    DUMP_CAP,
    DUMP_WAIT,
    DUMP_ACK
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= IDLE;
      addr        <= '0;
      remaining   <= '0;
      memWrEn     <= 1'b0;
      memAddr     <= '0;
      memWrData   <= '0;
      txStart     <= 1'b0;
      dataFromMem <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      memWrEn <= 1'b0;
      txStart <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (startLoad || startDump) begin
            remaining <= transLen;
            addr      <= '0;
            memAddr   <= '0;
            if (transLen == '0) begin
              done <= 1'b1;
            end else if (startLoad) begin
              state <= LOAD;
              busy  <= 1'b1;
            end else begin
              state <= DUMP_RD;
              busy  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (new_rx_data_indicate) begin
            memWrEn   <= 1'b1;
            memAddr   <= addr;
            memWrData <= dataToMem;
            addr      <= addr + ADDR_ONE;
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        // memAddr already holds addr on entry, so read data lands during DUMP_CAP
        DUMP_RD: state <= DUMP_CAP;
        DUMP_CAP: begin
          dataFromMem <= memRdData;
          state       <= DUMP_WAIT;
        end
        DUMP_WAIT: begin
          if (txReady) begin
            txStart <= 1'b1;
            state   <= DUMP_ACK;
          end
        end
        DUMP_ACK: begin
          addr      <= addr + ADDR_ONE;
          memAddr   <= addr + ADDR_ONE;
          remaining <= remaining - REM_ONE;
          if (remaining == REM_ONE) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= DUMP_RD;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      checksum <= '0;
    end else if (state == IDLE && (startLoad || startDump)) begin
      checksum <= '0;
    end else if (state == LOAD && new_rx_data_indicate) begin
      checksum <= checksum ^ dataToMem;
    end else if (state == DUMP_WAIT && txReady) begin
      checksum <= checksum ^ dataFromMem;
    end
  end
`endif

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb/tb_uart_mem_loader.sv - Randomized self-checking bench for uart_mem_loader against a queue-based reference.
module tb_uart_mem_loader;
  localparam int WS    = 24;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          startLoad = 1'b0;
  logic          startDump = 1'b0;
  logic [AW:0]   transLen = '0;
  logic          new_rx_data_indicate = 1'b0;
  logic [WS-1:0] dataToMem = '0;
  logic          txReady = 1'b1;
  logic [WS-1:0] memRdData;
  logic          memWrEn;
  logic [AW-1:0] memAddr;
  logic [WS-1:0] memWrData;
  logic          txStart;
  logic [WS-1:0] dataFromMem;
  logic          busy;
  logic          done;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [WS-1:0] checksum;
`endif

  always #5 clk = ~clk;

  uart_mem_loader #(.WORD_SIZE(WS), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstN(rstN), .startLoad(startLoad), .startDump(startDump),
    .transLen(transLen), .new_rx_data_indicate(new_rx_data_indicate),
    .dataToMem(dataToMem), .txReady(txReady), .memRdData(memRdData),
    .memWrEn(memWrEn), .memAddr(memAddr), .memWrData(memWrData),
    .txStart(txStart), .dataFromMem(dataFromMem), .busy(busy), .done(done)
`ifdef UART_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // Synchronous-read memory; pre_* lets the bench preload words without a second writer.
  logic [WS-1:0] mem [DEPTH];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [WS-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (memWrEn) mem[memAddr] <= memWrData;
    else if (pre_en) mem[pre_addr] <= pre_data;
    memRdData <= mem[memAddr];
  end

  // Encoder model: drops txReady after each txStart, raises it again a few cycles later.
  int enc_cnt = 0;
  always @(negedge clk) begin
    if (txStart) begin
      txReady = 1'b0;
      enc_cnt = $urandom_range(1, 4);
    end else if (enc_cnt > 0) begin
      enc_cnt = enc_cnt - 1;
      if (enc_cnt == 0) txReady = 1'b1;
    end
  end

  logic [AW-1:0] wr_addr_q[$];
  logic [WS-1:0] wr_data_q[$];
  logic [WS-1:0] tx_q[$];
  int            done_cnt = 0;
  always @(negedge clk) begin
    if (memWrEn) begin
      wr_addr_q.push_back(memAddr);
      wr_data_q.push_back(memWrData);
    end
    if (txStart) tx_q.push_back(dataFromMem);
    if (done) done_cnt = done_cnt + 1;
  end

  logic [WS-1:0] ref_mem [DEPTH];
  logic [WS-1:0] load_words[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    tx_q.delete();
    done_cnt = 0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic preload(input int a, input logic [WS-1:0] d);
    pre_en = 1'b1;
    pre_addr = AW'(a);
    pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // LOAD of load_words; optionally also asserts startDump with the start or mid-transfer.
  task automatic do_load(input string tag, input bit both, input bit poke_dump);
    int n = load_words.size();
    logic [WS-1:0] cs = '0;
    clear_mon();
    transLen = (AW+1)'(n);
    startLoad = 1'b1;
    startDump = both;
    @(negedge clk);
    startLoad = 1'b0;
    startDump = 1'b0;
    if (n == 0) check({tag, "_len0_done"}, 32'(done), 32'd1);
    else check({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (poke_dump && i == 1) startDump = 1'b1;
      new_rx_data_indicate = 1'b1;
      dataToMem = load_words[i];
      @(negedge clk);
      new_rx_data_indicate = 1'b0;
      startDump = 1'b0;
    end
    wait_done(8, tag);
    check({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'(n));
    check({tag, "_tx_count"}, 32'(tx_q.size()), 32'd0);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[i]), 32'(i % DEPTH));
      check($sformatf("%s_data%0d", tag, i), 32'(wr_data_q[i]), 32'(load_words[i]));
      ref_mem[i % DEPTH] = load_words[i];
      cs ^= load_words[i];
    end
`ifdef UART_LOADER_CHECKSUM_EN
    check({tag, "_checksum"}, 32'(checksum), 32'(cs));
`endif
  endtask

  task automatic do_dump(input string tag, input int n);
    logic [WS-1:0] cs = '0;
    clear_mon();
    transLen = (AW+1)'(n);
    startDump = 1'b1;
    @(negedge clk);
    startDump = 1'b0;
    if (n == 0) check({tag, "_len0_done"}, 32'(done), 32'd1);
    wait_done(20 * n + 10, tag);
    check({tag, "_tx_count"}, 32'(tx_q.size()), 32'(n));
    check({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'd0);
    for (int i = 0; i < n && i < tx_q.size(); i++) begin
      check($sformatf("%s_tx%0d", tag, i), 32'(tx_q[i]), 32'(ref_mem[i % DEPTH]));
      cs ^= ref_mem[i % DEPTH];
    end
`ifdef UART_LOADER_CHECKSUM_EN
    check({tag, "_checksum"}, 32'(checksum), 32'(cs));
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_memWrEn", 32'(memWrEn), 32'd0);
    check("rst_memAddr", 32'(memAddr), 32'd0);
    check("rst_memWrData", 32'(memWrData), 32'd0);
    check("rst_txStart", 32'(txStart), 32'd0);
    check("rst_dataFromMem", 32'(dataFromMem), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
`ifdef UART_LOADER_CHECKSUM_EN
    check("rst_checksum", 32'(checksum), 32'd0);
`endif
    rstN = 1'b1;
    clear_mon();
    repeat (5) @(negedge clk);
    check("post_rst_writes", 32'(wr_addr_q.size()), 32'd0);
    check("post_rst_tx", 32'(tx_q.size()), 32'd0);
    check("post_rst_done", 32'(done_cnt), 32'd0);

    for (int a = 0; a < DEPTH; a++) preload(a, WS'($urandom));

    load_words.delete();
    load_words.push_back(24'hA1B2C3);
    load_words.push_back(24'h000001);
    load_words.push_back(24'hFFFFFF);
    do_load("load3", 1'b0, 1'b0);
`ifdef UART_LOADER_CHECKSUM_EN
    check("load3_checksum_const", 32'(checksum), 32'h5E4D3D);
`endif

    preload(0, 24'h123456);
    preload(1, 24'hABCDEF);
    do_dump("dump2", 2);

    load_words.delete();
    do_load("load0", 1'b0, 1'b0);
    do_dump("dump0", 0);

    load_words.delete();
    repeat (2) load_words.push_back(WS'($urandom));
    do_load("both", 1'b1, 1'b0);

    load_words.delete();
    repeat (3) load_words.push_back(WS'($urandom));
    do_load("dump_ign", 1'b0, 1'b1);

    load_words.delete();
    repeat (4) load_words.push_back(WS'($urandom));
    do_load("wrap4", 1'b0, 1'b0);
    load_words.delete();
    load_words.push_back(WS'($urandom));
    do_load("after_wrap", 1'b0, 1'b0);

    clear_mon();
    new_rx_data_indicate = 1'b1;
    dataToMem = 24'h5A5A5A;
    @(negedge clk);
    new_rx_data_indicate = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_rx_writes", 32'(wr_addr_q.size()), 32'd0);
    check("stray_rx_done", 32'(done_cnt), 32'd0);

    clear_mon();
    transLen = 3'd4;
    startLoad = 1'b1;
    @(negedge clk);
    startLoad = 1'b0;
    for (int i = 0; i < 2; i++) begin
      new_rx_data_indicate = 1'b1;
      dataToMem = 24'h100 + WS'(i);
      @(negedge clk);
      new_rx_data_indicate = 1'b0;
      ref_mem[i] = 24'h100 + WS'(i);
    end
    rstN = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_memWrEn", 32'(memWrEn), 32'd0);
    check("abort_memAddr", 32'(memAddr), 32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_writes", 32'(wr_addr_q.size()), 32'd2);
    load_words.delete();
    repeat (2) load_words.push_back(WS'($urandom));
    do_load("restart", 1'b0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      int n = $urandom_range(0, DEPTH);
      if ($urandom_range(0, 1) == 1) begin
        load_words.delete();
        repeat (n) load_words.push_back(WS'($urandom));
        do_load($sformatf("rnd%0d_load", r), 1'b0, 1'b0);
      end else begin
        do_dump($sformatf("rnd%0d_dump", r), n);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
